// File: rtl/wave_sched_if.sv
// Signal bundle for wave_sched: game-logic frequency requests, the wave_logic
// engine port and the two read requesters (video, physics).
interface wave_sched_if;
  logic        freq_req;
  logic [4:0]  freq_req_id;
  logic        busy;
  logic        wave_valid;
  logic [4:0]  cur_id;
  logic        timeout_err;
  logic [4:0]  wl_freq_id;
  logic        wl_new_f;
  logic        wl_wave_ready;
  logic [10:0] wl_index;
  logic [9:0]  wl_wave_height;
  logic        vid_req;
  logic [10:0] vid_index;
  logic        vid_valid;
  logic [9:0]  vid_height;
  logic        phy_req;
  logic [10:0] phy_index;
  logic        phy_valid;
  logic [9:0]  phy_height;
  logic [1:0]  state_dbg;

  // Read handshake: a requester holds *_req/*_index until it sees *_valid;
  // *_valid is a one-cycle strobe qualifying *_height in that same cycle.
  modport slave (
    input  freq_req, freq_req_id, wl_wave_ready, wl_wave_height,
           vid_req, vid_index, phy_req, phy_index,
    output busy, wave_valid, cur_id, timeout_err, wl_freq_id, wl_new_f,
           wl_index, vid_valid, vid_height, phy_valid, phy_height, state_dbg
  );

  modport master (
    output freq_req, freq_req_id, wl_wave_ready, wl_wave_height,
           vid_req, vid_index, phy_req, phy_index,
    input  busy, wave_valid, cur_id, timeout_err, wl_freq_id, wl_new_f,
           wl_index, vid_valid, vid_height, phy_valid, phy_height, state_dbg
  );
endinterface

// File: rtl/wave_sched.sv
// Frequency-change sequencer and read-port arbiter in front of wave_logic.
// Issues new_f, waits for wave_ready (with watchdog), and shares the engine read port.
module wave_sched #(
  parameter int INIT_ID    = 12,
  parameter int MAX_ID     = 24,
  parameter int TIMEOUT    = 2048,
  parameter int STARVE_MAX = 4,
  parameter int FLAT_H     = 384
) (
  input  logic        clock,
  input  logic        reset,
  wave_sched_if.slave bus
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int SV_W = $clog2(STARVE_MAX + 1);
  localparam logic [4:0]      INIT_ID_V = 5'(INIT_ID);
  localparam logic [4:0]      MAX_ID_V  = 5'(MAX_ID);
  localparam logic [WD_W-1:0] TIMEOUT_V = WD_W'(TIMEOUT);
  localparam logic [SV_W-1:0] STARVE_V  = SV_W'(STARVE_MAX);
  localparam logic [9:0]      FLAT_V    = 10'(FLAT_H);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [4:0]      cur_id_q, cur_id_d;
  logic            pend_q, pend_d;
  logic [4:0]      pend_id_q, pend_id_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic            terr_q, terr_d;
  logic            new_f_q, new_f_d;
  logic [4:0]      req_id;

  assign req_id = (bus.freq_req_id > MAX_ID_V) ? MAX_ID_V : bus.freq_req_id;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ISSUE;
      cur_id_q  <= INIT_ID_V;
      pend_q    <= 1'b0;
      pend_id_q <= '0;
      wd_q      <= '0;
      busy_q    <= 1'b1;
      valid_q   <= 1'b0;
      terr_q    <= 1'b0;
      new_f_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_id_q  <= cur_id_d;
      pend_q    <= pend_d;
      pend_id_q <= pend_id_d;
      wd_q      <= wd_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      terr_q    <= terr_d;
      new_f_q   <= new_f_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_id_d  = cur_id_q;
    pend_d    = pend_q;
    pend_id_d = pend_id_q;
    wd_d      = wd_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    terr_d    = terr_q;
    new_f_d   = 1'b0;
    // Requests arriving while a waveform is in flight park here; latest wins.
    if (bus.freq_req && state_q != IDLE) begin
      pend_d    = 1'b1;
      pend_id_d = req_id;
    end
    case (state_q)
      IDLE: begin
        if (bus.freq_req && !(req_id == cur_id_q && valid_q)) begin
          cur_id_d = req_id;
          state_d  = ISSUE;
          busy_d   = 1'b1;
        end else if (pend_q) begin
          cur_id_d = pend_id_q;
          pend_d   = 1'b0;
          state_d  = ISSUE;
          busy_d   = 1'b1;
        end
      end
      ISSUE: begin
        new_f_d = 1'b1;
        valid_d = 1'b0;
        wd_d    = TIMEOUT_V;
        busy_d  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q - 1'b1;
        // A ready left over from the previous waveform is ignored while new_f is still up.
        if (bus.wl_wave_ready && !new_f_q) begin
          valid_d = 1'b1;
          if (pend_d) begin
            cur_id_d = pend_id_d;
            pend_d   = 1'b0;
            state_d  = ISSUE;
            busy_d   = 1'b1;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (wd_q == WD_W'(1)) begin
          terr_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      default: state_d = ISSUE;
    endcase
  end

  // Read arbitration: video has priority unless physics has starved STARVE_MAX cycles.
  logic            phy_force, vid_gnt, phy_gnt;
  logic [SV_W-1:0] starve_q;
  logic            s1_vid_q, s1_phy_q, s1_flat_q;
  logic [10:0]     index_q;
  logic            vid_valid_q, phy_valid_q;
  logic [9:0]      vid_height_q, phy_height_q;

  assign phy_force = bus.phy_req && (starve_q == STARVE_V);
  assign vid_gnt   = bus.vid_req && !phy_force;
  assign phy_gnt   = bus.phy_req && !vid_gnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q     <= '0;
      s1_vid_q     <= 1'b0;
      s1_phy_q     <= 1'b0;
      s1_flat_q    <= 1'b0;
      index_q      <= '0;
      vid_valid_q  <= 1'b0;
      phy_valid_q  <= 1'b0;
      vid_height_q <= '0;
      phy_height_q <= '0;
    end else begin
      vid_valid_q <= s1_vid_q;
      phy_valid_q <= s1_phy_q;
      if (s1_vid_q) vid_height_q <= s1_flat_q ? FLAT_V : bus.wl_wave_height;
      if (s1_phy_q) phy_height_q <= s1_flat_q ? FLAT_V : bus.wl_wave_height;
      if (valid_q) begin
        s1_vid_q  <= vid_gnt;
        s1_phy_q  <= phy_gnt;
        s1_flat_q <= 1'b0;
        if (vid_gnt) index_q <= bus.vid_index;
        else if (phy_gnt) index_q <= bus.phy_index;
        starve_q <= (bus.phy_req && vid_gnt) ? starve_q + 1'b1 : '0;
      end else begin
        // Table is being rewritten: answer everyone with the flat line, no engine access.
        s1_vid_q  <= bus.vid_req;
        s1_phy_q  <= bus.phy_req;
        s1_flat_q <= 1'b1;
        starve_q  <= '0;
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.wave_valid  = valid_q;
  assign bus.cur_id      = cur_id_q;
  assign bus.timeout_err = terr_q;
  assign bus.wl_freq_id  = cur_id_q;
  assign bus.wl_new_f    = new_f_q;
  assign bus.wl_index    = index_q;
  assign bus.vid_valid   = vid_valid_q;
  assign bus.vid_height  = vid_height_q;
  assign bus.phy_valid   = phy_valid_q;
  assign bus.phy_height  = phy_height_q;
  assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_wave_sched.sv
// Self-checking bench for wave_sched with a behavioural wave_logic model
// (ready 1026 cycles after new_f, height = index[9:0]).
module tb_wave_sched;
  logic clock;
  logic reset;
  wave_sched_if bus();

  wave_sched dut (.clock(clock), .reset(reset), .bus(bus));

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Engine model
  int         new_f_cnt = 0;
  logic [4:0] last_id = '0;
  logic       hang = 1'b0;
  int         rdy_cnt = 0;

  assign bus.wl_wave_height = bus.wl_index[9:0];

  initial begin
    bus.wl_wave_ready = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      if (reset) begin
        bus.wl_wave_ready = 1'b0;
        rdy_cnt = 0;
      end else if (bus.wl_new_f) begin
        new_f_cnt++;
        last_id = bus.wl_freq_id;
        bus.wl_wave_ready = 1'b0;
        rdy_cnt = 1026;
      end else if (rdy_cnt > 0) begin
        rdy_cnt--;
        if (rdy_cnt == 0 && !hang) bus.wl_wave_ready = 1'b1;
      end
    end
  end

  typedef struct {
    logic        vr;
    logic [10:0] vi;
    logic        pr;
    logic [10:0] pi;
    logic        ev;
    logic [9:0]  evh;
    logic        ep;
    logic [9:0]  eph;
  } vec_t;

  vec_t rd_vecs[6];
  vec_t flat_vecs[3];

  // Driver tasks
  task automatic freq_pulse(input logic [4:0] id);
    @(negedge clock);
    bus.freq_req = 1'b1;
    bus.freq_req_id = id;
    @(negedge clock);
    bus.freq_req = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n = 0;
    while (bus.busy && n < max_cyc) begin
      @(negedge clock);
      n++;
    end
    check(name, bus.busy, 1'b0);
  endtask

  task automatic wait_new_f(input string name, input int base, input int max_cyc);
    int n = 0;
    while (new_f_cnt == base && n < max_cyc) begin
      @(negedge clock);
      n++;
    end
    check(name, new_f_cnt, base + 1);
  endtask

  task automatic apply_vec(input string name, input vec_t v, input logic chk_idx,
                           input logic [10:0] exp_idx);
    @(negedge clock);
    bus.vid_req = v.vr;
    bus.vid_index = v.vi;
    bus.phy_req = v.pr;
    bus.phy_index = v.pi;
    @(negedge clock);
    bus.vid_req = 1'b0;
    bus.phy_req = 1'b0;
    @(negedge clock);
    check({name, "_vid_valid"}, bus.vid_valid, v.ev);
    check({name, "_phy_valid"}, bus.phy_valid, v.ep);
    if (v.ev) check({name, "_vid_height"}, bus.vid_height, v.evh);
    if (v.ep) check({name, "_phy_height"}, bus.phy_height, v.eph);
    if (chk_idx) check({name, "_wl_index"}, bus.wl_index, exp_idx);
  endtask

  initial begin
    int base;
    int k;
    logic exp_phy;

    rd_vecs[0] = '{1'b1, 11'd10,    1'b0, 11'd0,    1'b1, 10'd10,   1'b0, 10'd0};
    rd_vecs[1] = '{1'b0, 11'd0,     1'b1, 11'd20,   1'b0, 10'd0,    1'b1, 10'd20};
    rd_vecs[2] = '{1'b1, 11'd30,    1'b1, 11'd40,   1'b1, 10'd30,   1'b0, 10'd0};
    rd_vecs[3] = '{1'b1, 11'h7FF,   1'b0, 11'd0,    1'b1, 10'd1023, 1'b0, 10'd0};
    rd_vecs[4] = '{1'b0, 11'd0,     1'b1, 11'h400,  1'b0, 10'd0,    1'b1, 10'd0};
    rd_vecs[5] = '{1'b0, 11'd0,     1'b0, 11'd0,    1'b0, 10'd0,    1'b0, 10'd0};
    flat_vecs[0] = '{1'b1, 11'd5,   1'b1, 11'd500,  1'b1, 10'd384,  1'b1, 10'd384};
    flat_vecs[1] = '{1'b1, 11'd600, 1'b0, 11'd0,    1'b1, 10'd384,  1'b0, 10'd0};
    flat_vecs[2] = '{1'b0, 11'd0,   1'b1, 11'd9,    1'b0, 10'd0,    1'b1, 10'd384};

    reset = 1'b1;
    bus.freq_req = 1'b0;
    bus.freq_req_id = '0;
    bus.vid_req = 1'b0;
    bus.vid_index = '0;
    bus.phy_req = 1'b0;
    bus.phy_index = '0;
    repeat (3) @(negedge clock);

    // Reset values
    check("rst_busy", bus.busy, 1'b1);
    check("rst_wave_valid", bus.wave_valid, 1'b0);
    check("rst_cur_id", bus.cur_id, 5'd12);
    check("rst_timeout_err", bus.timeout_err, 1'b0);
    check("rst_new_f", bus.wl_new_f, 1'b0);
    check("rst_wl_freq_id", bus.wl_freq_id, 5'd12);
    check("rst_wl_index", bus.wl_index, 11'd0);
    check("rst_vid_valid", bus.vid_valid, 1'b0);
    check("rst_phy_valid", bus.phy_valid, 1'b0);
    check("rst_vid_height", bus.vid_height, 10'd0);
    check("rst_phy_height", bus.phy_height, 10'd0);
    check("rst_state", bus.state_dbg, 2'd1);
    reset = 1'b0;

    // Initial issue of INIT_ID; valid exactly one cycle after ready
    k = 0;
    while (!bus.wl_wave_ready && k < 3000) begin
      @(negedge clock);
      k++;
    end
    check("init_ready_seen", bus.wl_wave_ready, 1'b1);
    check("init_valid_before", bus.wave_valid, 1'b0);
    @(negedge clock);
    check("init_valid_after", bus.wave_valid, 1'b1);
    check("init_busy_after", bus.busy, 1'b0);
    check("init_new_f_cnt", new_f_cnt, 1);
    check("init_issue_id", last_id, 5'd12);

    // Clamp in IDLE, then duplicate request ignored
    freq_pulse(5'd30);
    check("clamp_cur_id", bus.cur_id, 5'd24);
    check("clamp_wl_freq_id", bus.wl_freq_id, 5'd24);
    check("clamp_busy", bus.busy, 1'b1);
    wait_idle("clamp_done", 3000);
    check("clamp_new_f_cnt", new_f_cnt, 2);
    check("clamp_issue_id", last_id, 5'd24);
    freq_pulse(5'd24);
    repeat (5) @(negedge clock);
    check("dup_new_f_cnt", new_f_cnt, 2);
    check("dup_busy", bus.busy, 1'b0);

    // Pending register: latest of 3, 7, 9 wins
    freq_pulse(5'd5);
    repeat (10) @(negedge clock);
    freq_pulse(5'd3);
    repeat (4) @(negedge clock);
    freq_pulse(5'd7);
    repeat (4) @(negedge clock);
    freq_pulse(5'd9);
    wait_idle("pend_done", 5000);
    check("pend_new_f_cnt", new_f_cnt, 4);
    check("pend_issue_id", last_id, 5'd9);
    check("pend_cur_id", bus.cur_id, 5'd9);
    repeat (10) @(negedge clock);
    check("pend_empty_cnt", new_f_cnt, 4);
    check("pend_state_idle", bus.state_dbg, 2'd0);

    // Valid-table read vectors
    for (int i = 0; i < 6; i++) apply_vec($sformatf("rd%0d", i), rd_vecs[i], 1'b0, 11'd0);

    // Both requesters held: physics wins every 5th grant
    @(negedge clock);
    bus.vid_req = 1'b1;
    bus.vid_index = 11'd100;
    bus.phy_req = 1'b1;
    bus.phy_index = 11'd200;
    for (int m = 1; m <= 11; m++) begin
      @(negedge clock);
      if (m >= 2) begin
        exp_phy = ((m - 1) % 5 == 0);
        check($sformatf("starve_phy_valid_%0d", m), bus.phy_valid, exp_phy);
        check($sformatf("starve_vid_valid_%0d", m), bus.vid_valid, !exp_phy);
        if (exp_phy) check($sformatf("starve_phy_h_%0d", m), bus.phy_height, 10'd200);
        else check($sformatf("starve_vid_h_%0d", m), bus.vid_height, 10'd100);
      end
    end
    bus.vid_req = 1'b0;
    bus.phy_req = 1'b0;
    repeat (2) @(negedge clock);

    // Read granted alongside a new request completes with engine data
    @(negedge clock);
    bus.vid_req = 1'b1;
    bus.vid_index = 11'd55;
    bus.freq_req = 1'b1;
    bus.freq_req_id = 5'd2;
    @(negedge clock);
    bus.vid_req = 1'b0;
    bus.freq_req = 1'b0;
    @(negedge clock);
    check("preissue_vid_valid", bus.vid_valid, 1'b1);
    check("preissue_vid_height", bus.vid_height, 10'd55);
    check("preissue_wave_valid", bus.wave_valid, 1'b0);

    // Flat reads while the table is rewritten
    for (int i = 0; i < 3; i++) apply_vec($sformatf("flat%0d", i), flat_vecs[i], 1'b1, 11'd55);
    wait_idle("flat_done", 3000);
    check("flat_issue_id", last_id, 5'd2);

    // Watchdog timeout and retry with the same id
    hang = 1'b1;
    base = new_f_cnt;
    freq_pulse(5'd6);
    wait_new_f("to_first_issue", base, 10);
    k = 0;
    while (!bus.timeout_err && k < 3000) begin
      @(negedge clock);
      k++;
    end
    check("to_cycles", k, 2048);
    @(negedge clock);
    check("to_retry_cnt", new_f_cnt, base + 2);
    check("to_retry_id", last_id, 5'd6);
    check("to_wave_valid", bus.wave_valid, 1'b0);

    // Reset mid-WAIT clears the sticky error and reissues INIT_ID
    repeat (100) @(negedge clock);
    check("to_sticky", bus.timeout_err, 1'b1);
    hang = 1'b0;
    base = new_f_cnt;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_timeout_err", bus.timeout_err, 1'b0);
    check("mid_rst_cur_id", bus.cur_id, 5'd12);
    check("mid_rst_state", bus.state_dbg, 2'd1);
    wait_new_f("mid_rst_issue", base, 10);
    check("mid_rst_issue_id", last_id, 5'd12);
    wait_idle("mid_rst_done", 3000);
    check("mid_rst_valid", bus.wave_valid, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
